// File: rtl/fp_mul_pipe.sv
// fp_mul_pipe: pipelined floating-point multiplier with valid/ready back-pressure.
// Operand register, then multiply, normalize and round stages; RNE, subnormal inputs flush to zero.
module fp_mul_pipe #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [EXP_W+MAN_W:0] flp_a,
   input  logic [EXP_W+MAN_W:0] flp_b,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [EXP_W+MAN_W:0] result,
   output logic                 overflow,
   output logic                 underflow,
   output logic                 invalid
);
   localparam int W   = 1 + EXP_W + MAN_W;
   localparam int SIG = MAN_W + 1;
   localparam int PW  = 2 * SIG;
   localparam int XW  = EXP_W + 2;
   localparam logic [XW-1:0] BIAS    = XW'((1 << (EXP_W - 1)) - 1);
   localparam logic [XW-1:0] EXP_TOP = XW'((1 << EXP_W) - 1);
   localparam logic [W-1:0]  QNAN    = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

   logic       advance;
   logic [3:0] valid_reg;

   // Every stage freezes together while the output is held by the consumer.
   assign advance   = ~(valid_reg[3] & ~out_ready);
   assign in_ready  = advance;
   assign out_valid = valid_reg[3];

   always_ff @(posedge clk) begin
      if (reset)
         valid_reg <= 4'b0000;
      else if (advance)
         valid_reg <= {valid_reg[2:0], in_valid};
   end

   logic [W-1:0] a_reg, b_reg;

   always_ff @(posedge clk) begin
      if (advance) begin
         a_reg <= flp_a;
         b_reg <= flp_b;
      end
   end

   logic [EXP_W-1:0] ea, eb;
   logic [MAN_W-1:0] fa, fb;
   logic             a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, sign_s1;

   assign ea      = a_reg[W-2 -: EXP_W];
   assign eb      = b_reg[W-2 -: EXP_W];
   assign fa      = a_reg[MAN_W-1:0];
   assign fb      = b_reg[MAN_W-1:0];
   assign a_nan   = (&ea) & (|fa);
   assign b_nan   = (&eb) & (|fb);
   assign a_inf   = (&ea) & ~(|fa);
   assign b_inf   = (&eb) & ~(|fb);
   assign a_zero  = ~(|ea);
   assign b_zero  = ~(|eb);
   assign sign_s1 = a_reg[W-1] ^ b_reg[W-1];

   logic         spec_next, spec_inv_next;
   logic [W-1:0] spec_res_next;

   always_comb begin
      spec_next     = 1'b1;
      spec_inv_next = 1'b0;
      spec_res_next = '0;
      if (a_nan | b_nan) begin
         spec_res_next = QNAN;
      end else if ((a_inf & b_zero) | (b_inf & a_zero)) begin
         spec_res_next = QNAN;
         spec_inv_next = 1'b1;
      end else if (a_inf | b_inf) begin
         spec_res_next = {sign_s1, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      end else if (a_zero | b_zero) begin
         spec_res_next = {sign_s1, {(W-1){1'b0}}};
      end else begin
         spec_next = 1'b0;
      end
   end

   logic          sign1_reg, spec1_reg, spec_inv1_reg;
   logic [W-1:0]  spec_res1_reg;
   logic [XW-1:0] exp1_reg;
   logic [PW-1:0] prod1_reg;

   // Exponent sum is kept two bits wider so it can go negative or past all-ones.
   always_ff @(posedge clk) begin
      if (advance) begin
         sign1_reg     <= sign_s1;
         spec1_reg     <= spec_next;
         spec_inv1_reg <= spec_inv_next;
         spec_res1_reg <= spec_res_next;
         exp1_reg      <= {2'b00, ea} + {2'b00, eb} - BIAS;
         prod1_reg     <= PW'({1'b1, fa}) * PW'({1'b1, fb});
      end
   end

   logic [PW-2:0] norm_s2;
   logic [XW-1:0] exp_s2;

   // norm_s2 has the hidden one removed; its top MAN_W bits are the fraction.
   assign norm_s2 = prod1_reg[PW-1] ? prod1_reg[PW-2:0] : {prod1_reg[PW-3:0], 1'b0};
   assign exp_s2  = exp1_reg + {{(XW-1){1'b0}}, prod1_reg[PW-1]};

   logic             sign2_reg, spec2_reg, spec_inv2_reg, guard2_reg, sticky2_reg;
   logic [W-1:0]     spec_res2_reg;
   logic [XW-1:0]    exp2_reg;
   logic [MAN_W-1:0] frac2_reg;

   always_ff @(posedge clk) begin
      if (advance) begin
         sign2_reg     <= sign1_reg;
         spec2_reg     <= spec1_reg;
         spec_inv2_reg <= spec_inv1_reg;
         spec_res2_reg <= spec_res1_reg;
         exp2_reg      <= exp_s2;
         frac2_reg     <= norm_s2[PW-2 -: MAN_W];
         guard2_reg    <= norm_s2[MAN_W];
         sticky2_reg   <= |norm_s2[MAN_W-1:0];
      end
   end

   logic           round_up, ovf_s3, unf_s3;
   logic [MAN_W:0] frac_sum;
   logic [XW-1:0]  exp_s3;

   // A carry out of the fraction leaves it all-zero, so only the exponent needs bumping.
   assign round_up = guard2_reg & (sticky2_reg | frac2_reg[0]);
   assign frac_sum = {1'b0, frac2_reg} + {{MAN_W{1'b0}}, round_up};
   assign exp_s3   = exp2_reg + {{(XW-1){1'b0}}, frac_sum[MAN_W]};
   assign ovf_s3   = ~exp_s3[XW-1] & (exp_s3 >= EXP_TOP);
   assign unf_s3   = exp_s3[XW-1] | (exp_s3 == '0);

   always_ff @(posedge clk) begin
      if (reset) begin
         result    <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
         invalid   <= 1'b0;
      end else if (advance) begin
         result    <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
         invalid   <= 1'b0;
         if (valid_reg[2]) begin
            if (spec2_reg) begin
               result  <= spec_res2_reg;
               invalid <= spec_inv2_reg;
            end else if (ovf_s3) begin
               result   <= {sign2_reg, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
               overflow <= 1'b1;
            end else if (unf_s3) begin
               result    <= {sign2_reg, {(W-1){1'b0}}};
               underflow <= 1'b1;
            end else begin
               result <= {sign2_reg, exp_s3[EXP_W-1:0], frac_sum[MAN_W-1:0]};
            end
         end
      end
   end
endmodule

// File: tb/tb_fp_mul_pipe.sv
// tb_fp_mul_pipe: directed and randomized checks of fp_mul_pipe (single precision)
// against an exact integer-arithmetic model and a scoreboard queue.
module tb_fp_mul_pipe;
   logic        clk = 1'b0;
   logic        reset, in_valid, in_ready, out_valid, out_ready;
   logic        overflow, underflow, invalid;
   logic [31:0] flp_a, flp_b, result;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [31:0] a, b, r;
      logic        ov, un, inv;
   } txn_t;

   txn_t exp_q[$];

   logic [31:0] dir_a [11] = '{32'h40A00000, 32'hC2400000, 32'h4568C000, 32'h3F800001,
                               32'h3F800001, 32'h7F000000, 32'h00800000, 32'h7F800000,
                               32'h7FC12345, 32'hFF800000, 32'h80000000};
   logic [31:0] dir_b [11] = '{32'h40400000, 32'hC1880000, 32'h44554000, 32'h3F800001,
                               32'h3FC00000, 32'h40000000, 32'h3F000000, 32'h00000000,
                               32'h3F800000, 32'h40000000, 32'h40000000};
   logic [31:0] dir_r [11] = '{32'h41700000, 32'h444C0000, 32'h4A41E1F0, 32'h3F800002,
                               32'h3FC00002, 32'h7F800000, 32'h00000000, 32'h7FC00000,
                               32'h7FC00000, 32'hFF800000, 32'h80000000};
   // {overflow, underflow, invalid}
   logic [2:0]  dir_f [11] = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b100,
                               3'b010, 3'b001, 3'b000, 3'b000, 3'b000};

   fp_mul_pipe #(.EXP_W(8), .MAN_W(23)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .flp_a     (flp_a),
      .flp_b     (flp_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .overflow  (overflow),
      .underflow (underflow),
      .invalid   (invalid)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   // Exact product of the two significands, rounded with remainder-versus-half arithmetic.
   function automatic txn_t model(input logic [31:0] a, input logic [31:0] b);
      txn_t            t;
      int              ea, eb, e, sh;
      longint unsigned sa, sb, p, q, rem, half;
      logic            sgn, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
      t.a = a; t.b = b; t.r = 32'h0; t.ov = 1'b0; t.un = 1'b0; t.inv = 1'b0;
      ea = int'(a[30:23]);
      eb = int'(b[30:23]);
      sgn    = a[31] ^ b[31];
      a_nan  = (ea == 255) && (a[22:0] != 23'd0);
      b_nan  = (eb == 255) && (b[22:0] != 23'd0);
      a_inf  = (ea == 255) && (a[22:0] == 23'd0);
      b_inf  = (eb == 255) && (b[22:0] == 23'd0);
      a_zero = (ea == 0);
      b_zero = (eb == 0);
      if (a_nan || b_nan) begin
         t.r = 32'h7FC00000;
      end else if ((a_inf && b_zero) || (b_inf && a_zero)) begin
         t.r = 32'h7FC00000;
         t.inv = 1'b1;
      end else if (a_inf || b_inf) begin
         t.r = {sgn, 8'hFF, 23'h0};
      end else if (a_zero || b_zero) begin
         t.r = {sgn, 31'h0};
      end else begin
         sa = 64'(a[22:0]) + (64'd1 << 23);
         sb = 64'(b[22:0]) + (64'd1 << 23);
         p  = sa * sb;
         e  = ea + eb - 127;
         if (p >= (64'd1 << 47)) begin
            sh = 24;
            e  = e + 1;
         end else begin
            sh = 23;
         end
         q    = p >> sh;
         rem  = p - (q << sh);
         half = 64'd1 << (sh - 1);
         if (rem > half || (rem == half && q[0])) q = q + 1;
         if (q == (64'd1 << 24)) begin
            q = q >> 1;
            e = e + 1;
         end
         if (e >= 255) begin
            t.r  = {sgn, 8'hFF, 23'h0};
            t.ov = 1'b1;
         end else if (e <= 0) begin
            t.r  = {sgn, 31'h0};
            t.un = 1'b1;
         end else begin
            t.r = {sgn, 8'(e), 23'(q)};
         end
      end
      return t;
   endfunction

   function automatic logic [31:0] rand_op();
      logic [31:0] v;
      v = $urandom;
      case ($urandom_range(0, 11))
         0: v[30:0] = 31'd0;
         1: v[30:0] = {8'hFF, 23'd0};
         2: v[30:0] = {8'hFF, 23'($urandom_range(1, 32'h7FFFFF))};
         3: v[30:23] = 8'd0;
         4: v[30:23] = 8'($urandom_range(190, 254));
         5: v[30:23] = 8'($urandom_range(1, 64));
         6: begin
            v[30:23] = 8'($urandom_range(110, 144));
            v[18:0]  = 19'd0;
         end
         default: v[30:23] = 8'($urandom_range(96, 158));
      endcase
      return v;
   endfunction

   function automatic logic [31:0] rand_normal();
      return {1'($urandom_range(0, 1)), 8'($urandom_range(100, 154)), 23'($urandom)};
   endfunction

   // Scoreboard and per-cycle protocol checks, sampled mid-cycle.
   logic        prev_stall = 1'b0;
   logic [34:0] held = '0;
   logic        acc_flag = 1'b0;
   int          run_len = 0;
   int          max_run = 0;
   int          n_out = 0;
   txn_t        mon_t;

   always @(negedge clk) begin
      if (reset) begin
         exp_q.delete();
         prev_stall = 1'b0;
         run_len    = 0;
         acc_flag   = 1'b0;
      end else begin
         chk("in_ready", 64'(in_ready), 64'(!(out_valid && !out_ready)));
         if (prev_stall)
            chk("stall_hold", 64'({out_valid, result, overflow, underflow, invalid}),
                64'({1'b1, held}));
         if (out_valid && out_ready) begin
            run_len++;
            if (run_len > max_run) max_run = run_len;
            if (exp_q.size() == 0) begin
               chk("spurious_out_valid", 64'(out_valid), 64'd0);
            end else begin
               mon_t = exp_q.pop_front();
               n_out++;
               $display("txn %0d: %h x %h -> %h ov=%0b un=%0b inv=%0b (want %h %0b%0b%0b)",
                        n_out, mon_t.a, mon_t.b, result, overflow, underflow, invalid,
                        mon_t.r, mon_t.ov, mon_t.un, mon_t.inv);
               chk("result", 64'(result), 64'(mon_t.r));
               chk("flags", 64'({overflow, underflow, invalid}),
                   64'({mon_t.ov, mon_t.un, mon_t.inv}));
            end
         end else begin
            run_len = 0;
         end
         acc_flag = in_valid && in_ready;
         if (in_valid && in_ready) exp_q.push_back(model(flp_a, flp_b));
         prev_stall = out_valid && !out_ready;
         held = {result, overflow, underflow, invalid};
      end
   end

   // Called at posedge+1; returns at posedge+1 after the edge that accepted the operands.
   task automatic send(input logic [31:0] a, input logic [31:0] b);
      int guard = 0;
      in_valid = 1'b1;
      flp_a = a;
      flp_b = b;
      @(negedge clk);
      while (!in_ready && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      if (!in_ready) chk("send_accept", 64'(in_ready), 64'd1);
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic drain(input string name);
      int n = 0;
      while ((exp_q.size() != 0 || out_valid) && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk(name, 64'(exp_q.size()), 64'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
      $fatal(1, "watchdog");
   end

   int          k, seen;
   logic [31:0] held_bp;

   initial begin
      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; flp_a = '0; flp_b = '0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("reset_out_valid", 64'(out_valid), 64'd0);
      chk("reset_result", 64'(result), 64'd0);
      chk("reset_flags", 64'({overflow, underflow, invalid}), 64'd0);
      chk("reset_in_ready", 64'(in_ready), 64'd1);

      for (int i = 0; i < 11; i++) begin
         txn_t m;
         m = model(dir_a[i], dir_b[i]);
         chk("model_pin", 64'({m.r, m.ov, m.un, m.inv}), 64'({dir_r[i], dir_f[i]}));
      end

      @(posedge clk);
      #1;
      send(32'h40A00000, 32'h40400000);
      k = 0;
      @(negedge clk);
      while (!out_valid && k < 10) begin
         @(negedge clk);
         k++;
      end
      chk("latency", 64'(k), 64'd3);
      drain("latency_drain");

      max_run = 0;
      for (int i = 0; i < 11; i++) send(dir_a[i], dir_b[i]);
      drain("burst_drain");
      chk("burst_throughput", 64'(max_run), 64'd11);

      max_run = 0;
      for (int i = 0; i < 3; i++) send(rand_normal(), rand_normal());
      out_ready = 1'b0;
      k = 0;
      @(negedge clk);
      while (!out_valid && k < 10) begin
         @(negedge clk);
         k++;
      end
      chk("bp_first_out", 64'(out_valid), 64'd1);
      held_bp = result;
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      flp_a = rand_normal();
      flp_b = rand_normal();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_in_ready", 64'(in_ready), 64'd0);
         chk("bp_result_stable", 64'(result), 64'(held_bp));
      end
      @(posedge clk);
      #1 out_ready = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      drain("bp_drain");
      chk("bp_run", 64'(max_run), 64'd3);

      send(rand_normal(), rand_normal());
      send(rand_normal(), rand_normal());
      reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("mid_reset_out_valid", 64'(out_valid), 64'd0);
      chk("mid_reset_result", 64'(result), 64'd0);
      chk("mid_reset_in_ready", 64'(in_ready), 64'd1);
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      chk("no_stale_result", 64'(seen), 64'd0);
      @(posedge clk);
      #1;

      for (int c = 0; c < 800; c++) begin
         out_ready = ($urandom_range(0, 3) != 0);
         if (!in_valid || acc_flag) begin
            in_valid = ($urandom_range(0, 9) < 7);
            flp_a = rand_op();
            flp_b = rand_op();
         end
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      drain("final_drain");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
